fifo_guarded: RTL and testbench
===============================

Name: fifo_guarded

Overview:
- Single-clock synchronous FIFO, next generation of the team's basic FIFO.
- Adds full-range occupancy count, overflow/underflow protection with sticky error flags, and runtime-programmable almost-full/almost-empty thresholds.
- Selectable show-ahead or normal read mode, with an optional output register in normal mode.
- Used as the generic buffering primitive between streaming stages.

Parameters:
- DWIDTH, 16, data word width.
- AWIDTH, 8, address width; DEPTH = 2**AWIDTH words.
- SHOWAHEAD, 1, 1 = head word presented on q_o without request; 0 = word delivered after rdreq_i.
- REGISTER_OUTPUT, 0, 1 = extra output register stage in normal mode (SHOWAHEAD=0); ignored when SHOWAHEAD=1.

Ports:
- clk_i  in  1  clock; sole clock domain.
- srst_i  in  1  synchronous reset, active-high.
- data_i  in  DWIDTH  write data.
- wrreq_i  in  1  write request.
- rdreq_i  in  1  read request.
- af_thresh_i  in  AWIDTH+1  almost-full threshold.
- ae_thresh_i  in  AWIDTH+1  almost-empty threshold.
- err_clr_i  in  1  clears sticky error flags.
- q_o  out  DWIDTH  read data.
- empty_o  out  1  usedw_o == 0.
- full_o  out  1  usedw_o == DEPTH.
- usedw_o  out  AWIDTH+1  stored word count, 0..DEPTH.
- almost_full_o  out  1  usedw_o >= af_thresh_i.
- almost_empty_o  out  1  usedw_o < ae_thresh_i.
- ovf_o  out  1  sticky: write attempted while full.
- udf_o  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (srst_i high at an edge):
  - Pointers and count go to 0; q_o = 0; ovf_o = udf_o = 0.
  - Resulting outputs: empty_o = 1, full_o = 0, almost_empty_o = (ae_thresh_i > 0).
  - Memory contents are not cleared.
  - Reset overrides all requests in the same cycle and aborts in-flight reads and register stages.
- Write acceptance:
  - wr_acc = wrreq_i & ~full_o.
  - On acceptance, data is stored at wr_ptr and wr_ptr increments mod DEPTH.
- Read acceptance:
  - rd_acc = rdreq_i & ~empty_o.
  - On acceptance, rd_ptr increments mod DEPTH.
- Count update:
  - usedw_o +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.
  - Must never exceed DEPTH or go below 0.
- Full with simultaneous requests: rd_acc is taken, the write is dropped, ovf_o sets. Result: count DEPTH-1.
- Empty with simultaneous requests: the write is taken, the read is dropped, udf_o sets. Result: count 1.
- Pointer wrap: pointers are AWIDTH bits and wrap naturally. Full vs empty is distinguished only by the count, never by pointer equality.
- Sticky errors:
  - ovf_o sets at the edge after wrreq_i & full_o; udf_o sets at the edge after rdreq_i & empty_o.
  - Both clear on err_clr_i. A set condition in the same cycle as err_clr_i wins (flag stays 1).
- SHOWAHEAD=1:
  - Whenever empty_o = 0, q_o equals the oldest stored word, combinationally valid.
  - rd_acc at edge N: q_o shows the next word from edge N.
  - A write into an empty FIFO at edge N gives empty_o = 0 and q_o = the written word from edge N.
  - This requires write-to-read bypass; no extra bubble is permitted.
  - When empty, q_o holds its last value.
- SHOWAHEAD=0, REGISTER_OUTPUT=0:
  - rd_acc at edge N: q_o updates at edge N with the word at rd_ptr, i.e. a 1-cycle latency from request.
  - q_o holds between reads; dropped reads do not change q_o.
- SHOWAHEAD=0, REGISTER_OUTPUT=1: same as above with q_o updated one edge later (N+1), i.e. a 2-cycle latency.
- Flag timing:
  - empty_o, full_o, almost_full_o and almost_empty_o are decoded combinationally from the registered count and the threshold inputs; there is no added latency.
  - Thresholds may change at any time and take effect immediately.
  - af_thresh_i = 0 forces almost_full_o = 1; ae_thresh_i = 0 forces almost_empty_o = 0.

Test Plan:
- Fill/drain (AWIDTH=4, DWIDTH=16, SHOWAHEAD=1): write 16 words 0x0000..0x000F.
  - Expect full_o = 1 and usedw_o = 16.
  - Read 16: q_o presents 0x0000..0x000F in order, then empty_o = 1.
- Overflow: at full, write 0xDEAD.
  - Expect the write dropped, ovf_o = 1, usedw_o = 16, and the data order unchanged on drain.
  - Pulse err_clr_i -> ovf_o = 0.
- Underflow: on empty, read.
  - Expect udf_o = 1, usedw_o = 0, q_o unchanged.
  - Simultaneous write 0x1234 with read on empty -> usedw_o = 1, q_o = 0x1234 the next cycle, udf_o = 1.
- Full with simultaneous rd+wr: expect usedw_o = 15, ovf_o = 1, and the head word advanced.
- Wrap-around stress: 1000 cycles of random rd/wr with thresholds af=12, ae=3.
  - Compare data against a reference queue.
  - Check flags every cycle against the model count.
- Latency (SHOWAHEAD=0): rdreq_i at edge N.
  - REGISTER_OUTPUT=0: q_o is valid after edge N.
  - REGISTER_OUTPUT=1: q_o is valid after edge N+1.
  - srst_i mid-burst: q_o = 0, empty_o = 1, no stale word emerges afterwards.

Source files
------------

// File: rtl/fifo_guarded_if.sv
// rtl/fifo_guarded_if.sv - request, data and status bundle for fifo_guarded
// The FIFO sits on the slave side; the producer/consumer logic uses master.
interface fifo_guarded_if #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 8
);
    logic [DWIDTH-1:0] data_i;
    logic              wrreq_i;
    logic              rdreq_i;
    logic [AWIDTH:0]   af_thresh_i;
    logic [AWIDTH:0]   ae_thresh_i;
    logic              err_clr_i;
    logic [DWIDTH-1:0] q_o;
    logic              empty_o;
    logic              full_o;
    logic [AWIDTH:0]   usedw_o;
    logic              almost_full_o;
    logic              almost_empty_o;
    logic              ovf_o;
    logic              udf_o;

    modport master (
        output data_i, wrreq_i, rdreq_i, af_thresh_i, ae_thresh_i, err_clr_i,
        input  q_o, empty_o, full_o, usedw_o, almost_full_o, almost_empty_o, ovf_o, udf_o
    );

    modport slave (
        input  data_i, wrreq_i, rdreq_i, af_thresh_i, ae_thresh_i, err_clr_i,
        output q_o, empty_o, full_o, usedw_o, almost_full_o, almost_empty_o, ovf_o, udf_o
    );
endinterface

// File: rtl/fifo_guarded.sv
// rtl/fifo_guarded.sv - single-clock FIFO with occupancy count, sticky errors and thresholds
// Full/empty come only from the count, so pointers may wrap freely.
module fifo_guarded #(
    parameter int DWIDTH          = 16,
    parameter int AWIDTH          = 8,
    parameter int SHOWAHEAD       = 1,
    parameter int REGISTER_OUTPUT = 0
) (
    input  logic          clk_i,
    input  logic          srst_i,
    fifo_guarded_if.slave bus
);
    localparam int              DEPTH    = 1 << AWIDTH;
    localparam logic [AWIDTH:0] FULL_CNT = (AWIDTH + 1)'(DEPTH);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              empty, full, wr_acc, rd_acc;
    logic [DWIDTH-1:0] head;

    always_comb begin
        empty    = (cnt_q == '0);
        full     = (cnt_q == FULL_CNT);
        wr_acc   = bus.wrreq_i & ~full;
        rd_acc   = bus.rdreq_i & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr_acc && !rd_acc) begin
            cnt_d = cnt_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            cnt_d = cnt_q - 1'b1;
        end
        // A fresh error in the clearing cycle keeps the flag set.
        ovf_d = (bus.wrreq_i & full)  | (ovf_q & ~bus.err_clr_i);
        udf_d = (bus.rdreq_i & empty) | (udf_q & ~bus.err_clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (!srst_i && wr_acc) mem_q[wr_ptr_q] <= bus.data_i;
    end

    assign head = mem_q[rd_ptr_q];

    generate
        if (SHOWAHEAD != 0) begin : g_showahead
            // Asynchronous read makes a word written at an edge visible right after it.
            logic [DWIDTH-1:0] hold_q;
            always_ff @(posedge clk_i) begin
                if (srst_i)      hold_q <= '0;
                else if (!empty) hold_q <= head;
            end
            assign bus.q_o = empty ? hold_q : head;
        end else if (REGISTER_OUTPUT != 0) begin : g_regout
            logic [DWIDTH-1:0] stage_q;
            logic              stage_vld_q;
            logic [DWIDTH-1:0] q_q;
            always_ff @(posedge clk_i) begin
                if (srst_i) begin
                    stage_q     <= '0;
                    stage_vld_q <= 1'b0;
                    q_q         <= '0;
                end else begin
                    stage_vld_q <= rd_acc;
                    if (rd_acc)      stage_q <= head;
                    if (stage_vld_q) q_q     <= stage_q;
                end
            end
            assign bus.q_o = q_q;
        end else begin : g_normal
            logic [DWIDTH-1:0] q_q;
            always_ff @(posedge clk_i) begin
                if (srst_i)      q_q <= '0;
                else if (rd_acc) q_q <= head;
            end
            assign bus.q_o = q_q;
        end
    endgenerate

    assign bus.empty_o        = empty;
    assign bus.full_o         = full;
    assign bus.usedw_o        = cnt_q;
    assign bus.almost_full_o  = (cnt_q >= bus.af_thresh_i);
    assign bus.almost_empty_o = (cnt_q < bus.ae_thresh_i);
    assign bus.ovf_o          = ovf_q;
    assign bus.udf_o          = udf_q;
endmodule

// File: tb/tb_fifo_guarded.sv
// tb/tb_fifo_guarded.sv - directed and random checks of fifo_guarded in all three read modes
module tb_fifo_guarded;
    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    fifo_guarded_if #(.DWIDTH(16), .AWIDTH(4)) if_sa ();
    fifo_guarded_if #(.DWIDTH(16), .AWIDTH(4)) if_n0 ();
    fifo_guarded_if #(.DWIDTH(16), .AWIDTH(4)) if_n1 ();

    fifo_guarded #(.DWIDTH(16), .AWIDTH(4), .SHOWAHEAD(1), .REGISTER_OUTPUT(0))
        u_sa (.clk_i(clk), .srst_i(srst), .bus(if_sa.slave));
    fifo_guarded #(.DWIDTH(16), .AWIDTH(4), .SHOWAHEAD(0), .REGISTER_OUTPUT(0))
        u_n0 (.clk_i(clk), .srst_i(srst), .bus(if_n0.slave));
    fifo_guarded #(.DWIDTH(16), .AWIDTH(4), .SHOWAHEAD(0), .REGISTER_OUTPUT(1))
        u_n1 (.clk_i(clk), .srst_i(srst), .bus(if_n1.slave));

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] ref_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sa_drive(input logic wr, input logic rd, input logic [15:0] d);
        if_sa.wrreq_i = wr;
        if_sa.rdreq_i = rd;
        if_sa.data_i  = d;
    endtask

    task automatic n_drive(input logic wr, input logic rd, input logic [15:0] d);
        if_n0.wrreq_i = wr;
        if_n0.rdreq_i = rd;
        if_n0.data_i  = d;
        if_n1.wrreq_i = wr;
        if_n1.rdreq_i = rd;
        if_n1.data_i  = d;
    endtask

    task automatic sa_errclr();
        if_sa.err_clr_i = 1'b1;
        tick();
        if_sa.err_clr_i = 1'b0;
    endtask

    initial begin
        logic        wr_b, rd_b, wbias;
        logic [15:0] dv;
        int          sz;

        srst = 1'b1;
        sa_drive(1'b0, 1'b0, 16'h0);
        n_drive(1'b0, 1'b0, 16'h0);
        if_sa.af_thresh_i = 5'd12; if_sa.ae_thresh_i = 5'd3; if_sa.err_clr_i = 1'b0;
        if_n0.af_thresh_i = 5'd12; if_n0.ae_thresh_i = 5'd3; if_n0.err_clr_i = 1'b0;
        if_n1.af_thresh_i = 5'd12; if_n1.ae_thresh_i = 5'd3; if_n1.err_clr_i = 1'b0;
        tick();
        tick();
        srst = 1'b0;

        chk("rst_empty", 32'(if_sa.empty_o), 32'd1);
        chk("rst_full", 32'(if_sa.full_o), 32'd0);
        chk("rst_usedw", 32'(if_sa.usedw_o), 32'd0);
        chk("rst_q", 32'(if_sa.q_o), 32'd0);
        chk("rst_ovf", 32'(if_sa.ovf_o), 32'd0);
        chk("rst_udf", 32'(if_sa.udf_o), 32'd0);
        chk("rst_ae", 32'(if_sa.almost_empty_o), 32'd1);
        chk("rst_af", 32'(if_sa.almost_full_o), 32'd0);
        chk("rst_n1_q", 32'(if_n1.q_o), 32'd0);

        if_sa.af_thresh_i = 5'd0;
        #1 chk("af_zero", 32'(if_sa.almost_full_o), 32'd1);
        if_sa.af_thresh_i = 5'd12;
        if_sa.ae_thresh_i = 5'd0;
        #1 chk("ae_zero", 32'(if_sa.almost_empty_o), 32'd0);
        if_sa.ae_thresh_i = 5'd3;

        for (int i = 0; i < 16; i++) begin
            sa_drive(1'b1, 1'b0, 16'(i));
            tick();
            chk("fill_usedw", 32'(if_sa.usedw_o), 32'(i + 1));
        end
        sa_drive(1'b0, 1'b0, 16'h0);
        chk("fill_full", 32'(if_sa.full_o), 32'd1);
        chk("fill_af", 32'(if_sa.almost_full_o), 32'd1);
        chk("fill_ae", 32'(if_sa.almost_empty_o), 32'd0);

        sa_drive(1'b1, 1'b0, 16'hDEAD);
        tick();
        sa_drive(1'b0, 1'b0, 16'h0);
        chk("ovf_set", 32'(if_sa.ovf_o), 32'd1);
        chk("ovf_usedw", 32'(if_sa.usedw_o), 32'd16);
        if_sa.err_clr_i = 1'b1;
        sa_drive(1'b1, 1'b0, 16'hDEAD);
        tick();
        chk("ovf_set_wins", 32'(if_sa.ovf_o), 32'd1);
        sa_drive(1'b0, 1'b0, 16'h0);
        tick();
        if_sa.err_clr_i = 1'b0;
        chk("ovf_clr", 32'(if_sa.ovf_o), 32'd0);

        for (int i = 0; i < 16; i++) begin
            chk("drain_q", 32'(if_sa.q_o), 32'(i));
            sa_drive(1'b0, 1'b1, 16'h0);
            tick();
        end
        sa_drive(1'b0, 1'b0, 16'h0);
        chk("drain_empty", 32'(if_sa.empty_o), 32'd1);
        chk("drain_usedw", 32'(if_sa.usedw_o), 32'd0);
        chk("drain_hold_q", 32'(if_sa.q_o), 32'h000F);

        sa_drive(1'b0, 1'b1, 16'h0);
        tick();
        sa_drive(1'b0, 1'b0, 16'h0);
        chk("udf_set", 32'(if_sa.udf_o), 32'd1);
        chk("udf_usedw", 32'(if_sa.usedw_o), 32'd0);
        chk("udf_q", 32'(if_sa.q_o), 32'h000F);
        sa_errclr();
        chk("udf_clr", 32'(if_sa.udf_o), 32'd0);

        sa_drive(1'b1, 1'b1, 16'h1234);
        tick();
        sa_drive(1'b0, 1'b0, 16'h0);
        chk("empty_rw_usedw", 32'(if_sa.usedw_o), 32'd1);
        chk("empty_rw_q", 32'(if_sa.q_o), 32'h1234);
        chk("empty_rw_udf", 32'(if_sa.udf_o), 32'd1);
        sa_drive(1'b0, 1'b1, 16'h0);
        tick();
        sa_drive(1'b0, 1'b0, 16'h0);
        chk("empty_rw_drain", 32'(if_sa.empty_o), 32'd1);
        sa_errclr();

        for (int i = 0; i < 16; i++) begin
            sa_drive(1'b1, 1'b0, 16'(16'h0100 + i));
            tick();
        end
        chk("full2_full", 32'(if_sa.full_o), 32'd1);
        sa_drive(1'b1, 1'b1, 16'hBEEF);
        tick();
        sa_drive(1'b0, 1'b0, 16'h0);
        chk("full_rw_usedw", 32'(if_sa.usedw_o), 32'd15);
        chk("full_rw_ovf", 32'(if_sa.ovf_o), 32'd1);
        chk("full_rw_head", 32'(if_sa.q_o), 32'h0101);
        for (int i = 0; i < 15; i++) begin
            chk("full_rw_drain_q", 32'(if_sa.q_o), 32'(16'h0101 + i));
            sa_drive(1'b0, 1'b1, 16'h0);
            tick();
        end
        sa_drive(1'b0, 1'b0, 16'h0);
        chk("full_rw_empty", 32'(if_sa.empty_o), 32'd1);
        sa_errclr();

        // Alternating write-heavy and read-heavy phases so full and empty both get hit.
        for (int c = 0; c < 1000; c++) begin
            wbias = (((c / 100) % 2) == 0);
            wr_b  = wbias ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            rd_b  = wbias ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
            dv    = 16'($urandom);
            if (ref_q.size() != 0) chk("stress_q", 32'(if_sa.q_o), 32'(ref_q[0]));
            sa_drive(wr_b, rd_b, dv);
            sz = ref_q.size();
            if (rd_b && sz != 0) void'(ref_q.pop_front());
            if (wr_b && sz != 16) ref_q.push_back(dv);
            tick();
            sz = ref_q.size();
            chk("stress_usedw", 32'(if_sa.usedw_o), 32'(sz));
            chk("stress_empty", 32'(if_sa.empty_o), 32'(sz == 0));
            chk("stress_full", 32'(if_sa.full_o), 32'(sz == 16));
            chk("stress_af", 32'(if_sa.almost_full_o), 32'(sz >= 12));
            chk("stress_ae", 32'(if_sa.almost_empty_o), 32'(sz < 3));
        end
        sa_drive(1'b0, 1'b0, 16'h0);

        srst = 1'b1;
        tick();
        srst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_drive(1'b1, 1'b0, 16'(16'h00A0 + i));
            tick();
        end
        n_drive(1'b0, 1'b0, 16'h0);
        chk("lat_n0_idle", 32'(if_n0.q_o), 32'd0);
        chk("lat_n1_idle", 32'(if_n1.q_o), 32'd0);
        n_drive(1'b0, 1'b1, 16'h0);
        tick();
        n_drive(1'b0, 1'b0, 16'h0);
        chk("lat_n0_N", 32'(if_n0.q_o), 32'h00A0);
        chk("lat_n1_N", 32'(if_n1.q_o), 32'd0);
        tick();
        chk("lat_n1_N1", 32'(if_n1.q_o), 32'h00A0);
        chk("lat_n0_hold", 32'(if_n0.q_o), 32'h00A0);
        n_drive(1'b0, 1'b1, 16'h0);
        tick();
        n_drive(1'b0, 1'b0, 16'h0);
        chk("lat_n0_2nd", 32'(if_n0.q_o), 32'h00A1);
        chk("lat_n1_2nd_early", 32'(if_n1.q_o), 32'h00A0);
        tick();
        chk("lat_n1_2nd", 32'(if_n1.q_o), 32'h00A1);
        n_drive(1'b0, 1'b1, 16'h0);
        tick();
        n_drive(1'b0, 1'b0, 16'h0);
        tick();
        chk("lat_n0_3rd", 32'(if_n0.q_o), 32'h00A2);
        chk("lat_n1_3rd", 32'(if_n1.q_o), 32'h00A2);
        chk("lat_n0_empty", 32'(if_n0.empty_o), 32'd1);
        n_drive(1'b0, 1'b1, 16'h0);
        tick();
        n_drive(1'b0, 1'b0, 16'h0);
        tick();
        chk("drop_n0_q", 32'(if_n0.q_o), 32'h00A2);
        chk("drop_n1_q", 32'(if_n1.q_o), 32'h00A2);
        chk("drop_n0_udf", 32'(if_n0.udf_o), 32'd1);

        n_drive(1'b1, 1'b0, 16'h00B0);
        tick();
        n_drive(1'b1, 1'b0, 16'h00B1);
        tick();
        n_drive(1'b0, 1'b1, 16'h0);
        tick();
        chk("burst_n0_q", 32'(if_n0.q_o), 32'h00B0);
        srst = 1'b1;
        tick();
        chk("srst_n0_q", 32'(if_n0.q_o), 32'd0);
        chk("srst_n1_q", 32'(if_n1.q_o), 32'd0);
        chk("srst_n1_empty", 32'(if_n1.empty_o), 32'd1);
        chk("srst_n0_udf", 32'(if_n0.udf_o), 32'd0);
        srst = 1'b0;
        n_drive(1'b0, 1'b0, 16'h0);
        tick();
        tick();
        chk("post_srst_n1_q", 32'(if_n1.q_o), 32'd0);
        chk("post_srst_n0_q", 32'(if_n0.q_o), 32'd0);
        chk("post_srst_n1_usedw", 32'(if_n1.usedw_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
